pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter register and sequences instruction fetch against the instruction-memory handshake (iREN/ihit).
- Resolves next-PC from sequential, branch, jump-immediate and jump-register sources, and honours hazard-unit stalls.
- Buffers redirects that arrive while a fetch is outstanding.
- Freezes on halt.
- Sits between the hazard/control logic and the icache/imem port in the pipelined MIPS core.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold PC, suppress update
halt  input  1  halt instruction decoded; stop fetching
branch_en  input  1  taken branch redirect
branch_addr  input  16  branch immediate, word offset, signed
jump_en  input  1  j/jal redirect
jumpi_addr  input  26  jump immediate field
jr_en  input  1  jr redirect
jr_addr  input  32  register jump target
ihit  input  1  imem returns instruction for iaddr this cycle
iREN  output  1  instruction read request
iaddr  output  32  fetch address (= PC register)
pc_plus4  output  32  PC + 4
ivalid  output  1  fetched instruction accepted this cycle
halted  output  1  sequencer frozen
misalign  output  1  misaligned jr target detected (see Optional Feature)

Behaviour:
- Reset (async, nRST=0): pc=PC_INIT, state=IDLE, iREN=0, ivalid=0, halted=0, misalign=0, pending_v=0, pending_addr=0.
- States:
  - IDLE: iREN=0. Advances to FETCH next cycle unconditionally.
  - FETCH: iREN=1, iaddr=pc.
  - HALTED: iREN=0, halted=1. Exits only via reset.
- Target arithmetic, all 32-bit, wraps mod 2^32, computed from current pc:
  - branch target = pc_plus4 + ({{14{branch_addr[15]}}, branch_addr, 2'b00}).
  - jump target = {pc_plus4[31:28], jumpi_addr, 2'b00}.
  - jr target = jr_addr.
- Redirect priority when several enables are high in one cycle: jr_en > jump_en > branch_en.
- Update condition: upd = (state==FETCH) && ihit && !stall. ivalid = upd, combinational.
- When upd:
  - halt=1: state->HALTED, pc unchanged, pending cleared. Halt beats any redirect.
  - Else if a redirect enable is high this cycle: pc <= selected target; pending cleared.
  - Else if pending_v: pc <= pending_addr; pending_v <= 0.
  - Else: pc <= pc_plus4.
- Redirect without upd, in FETCH (ihit=0 or stall=1): pending_addr <= selected target, pending_v <= 1. A newer redirect overwrites an older pending one. pc is not changed; iREN stays 1 at the old address.
- stall=1 with ihit=1: no update, ivalid=0, iREN remains 1 (refetch same address).
- halt with ihit=0 or stall=1: ignored until an upd cycle; halt must be held by control until then.
- Redirect/halt inputs are ignored in IDLE and HALTED.
- Reset mid-fetch: immediate return to the reset state above; the outstanding fetch is abandoned.
- Latency:
  - Redirect seen on an upd cycle: iaddr shows the new target the following cycle.
  - Pending redirect: applied at the next upd.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: a selected jr target with jr_addr[1:0]!=0 is treated as a fault, whether taken at upd or when captured into pending.
  - misalign <= 1 (sticky until reset).
  - state -> HALTED at the next clock; pc unchanged.
  - The target is not loaded or buffered.
- Undefined: misalign is tied 0 and jr_addr is used unmodified, low bits included.

Test Plan:
- Reset with PC_INIT=0x0000_0040, ihit=1 every cycle -> IDLE one cycle, then iaddr 0x40, 0x44, 0x48; ivalid=1 each FETCH cycle; halted=0.
- pc=0x100, branch_en=1, branch_addr=16'hFFFE, ihit=1 -> next iaddr=0x0FC. Repeat with jump_en=1, jumpi_addr=26'h000_0010 -> 0x040.
- pc=0x200, ihit=0, jump_en=1 pulse (jumpi_addr=0x80) -> iaddr stays 0x200 with iREN=1; at the later ihit, next iaddr=0x200 and pending is cleared.
- Same-cycle jr_en (jr_addr=0x1000), jump_en and branch_en with ihit=1 -> next iaddr=0x1000. Then stall=1 with ihit=1 for 3 cycles -> iaddr held at 0x1000, ivalid=0.
- halt=1 together with branch_en=1 on an upd cycle -> HALTED, iREN=0, halted=1, pc frozen. Later inputs ignored; nRST pulse returns iaddr to PC_INIT.
- With PC_ALIGN_CHECK_EN defined: jr_en=1, jr_addr=0x1002, ihit=1 -> misalign=1, halted=1, pc unchanged. Without the macro -> next iaddr=0x1002, misalign=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, next-PC selection, buffered redirects, halt.
// Optional macro PC_ALIGN_CHECK_EN enables misaligned jr-target fault detection.
module pc_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_en,
    input  logic [15:0] branch_addr,
    input  logic        jump_en,
    input  logic [25:0] jumpi_addr,
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    input  logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] pc_plus4,
    output logic        ivalid,
    output logic        halted,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pend_addr, pend_addr_n;
    logic        pend_v, pend_v_n;
    logic        mis_q, mis_n;
    logic [31:0] branch_tgt, jump_tgt, sel_tgt;
    logic        redirect, upd, jr_fault;

    assign pc_plus4   = pc + 32'd4;
    assign branch_tgt = pc_plus4 + {{14{branch_addr[15]}}, branch_addr, 2'b00};
    assign jump_tgt   = {pc_plus4[31:28], jumpi_addr, 2'b00};
    assign redirect   = jr_en | jump_en | branch_en;
    assign upd        = (state == FETCH) && ihit && !stall;

    always_comb begin
        sel_tgt = branch_tgt;
        if (jr_en)        sel_tgt = jr_addr;
        else if (jump_en) sel_tgt = jump_tgt;
    end

`ifdef PC_ALIGN_CHECK_EN
    // jr has top priority, so jr_en alone means jr is the selected source; halt on upd still wins
    assign jr_fault = (state == FETCH) && jr_en && (jr_addr[1:0] != 2'b00) && !(upd && halt);
`else
    assign jr_fault = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            pc        <= PC_INIT;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            mis_q     <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            pend_v    <= pend_v_n;
            pend_addr <= pend_addr_n;
            mis_q     <= mis_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_v_n    = pend_v;
        pend_addr_n = pend_addr;
        mis_n       = mis_q;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (jr_fault) begin
                    mis_n   = 1'b1;
                    state_n = HALTED;
                end else if (upd) begin
                    if (halt) begin
                        state_n  = HALTED;
                        pend_v_n = 1'b0;
                    end else if (redirect) begin
                        pc_n     = sel_tgt;
                        pend_v_n = 1'b0;
                    end else if (pend_v) begin
                        pc_n     = pend_addr;
                        pend_v_n = 1'b0;
                    end else begin
                        pc_n = pc_plus4;
                    end
                end else if (redirect) begin
                    pend_addr_n = sel_tgt;
                    pend_v_n    = 1'b1;
                end
            end
            HALTED: state_n = HALTED;
            default: state_n = IDLE;
        endcase
    end

    assign iREN     = (state == FETCH);
    assign iaddr    = pc;
    assign ivalid   = upd;
    assign halted   = (state == HALTED);
    assign misalign = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (PC_INIT=0x40); honours PC_ALIGN_CHECK_EN if defined.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        stall = 1'b0, halt = 1'b0, branch_en = 1'b0, jump_en = 1'b0, jr_en = 1'b0, ihit = 1'b0;
    logic [15:0] branch_addr = '0;
    logic [25:0] jumpi_addr = '0;
    logic [31:0] jr_addr = '0;
    logic        iREN, ivalid, halted, misalign;
    logic [31:0] iaddr, pc_plus4;

    typedef struct packed {
        logic        halt, stall, ihit, br, j, jr;
        logic [15:0] ba;
        logic [25:0] ja;
        logic [31:0] jra;
    } stim_t;

    typedef struct packed {
        logic        iren, ivalid, halted, misalign;
        logic [31:0] iaddr;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer #(.PC_INIT(32'h0000_0040)) dut (
        .CLK(CLK), .nRST(nRST), .stall(stall), .halt(halt),
        .branch_en(branch_en), .branch_addr(branch_addr),
        .jump_en(jump_en), .jumpi_addr(jumpi_addr),
        .jr_en(jr_en), .jr_addr(jr_addr), .ihit(ihit),
        .iREN(iREN), .iaddr(iaddr), .pc_plus4(pc_plus4),
        .ivalid(ivalid), .halted(halted), .misalign(misalign)
    );

    always #5 CLK = ~CLK;

    function automatic stim_t S(input logic h, st, ih, b, j, r,
                                input logic [15:0] ba, input logic [25:0] ja, input logic [31:0] jra);
        S = {h, st, ih, b, j, r, ba, ja, jra};
    endfunction

    function automatic obs_t E(input logic ren, v, hl, m, input logic [31:0] a);
        E = {ren, v, hl, m, a};
    endfunction

    task automatic drive(input stim_t s);
        halt = s.halt; stall = s.stall; ihit = s.ihit;
        branch_en = s.br; jump_en = s.j; jr_en = s.jr;
        branch_addr = s.ba; jumpi_addr = s.ja; jr_addr = s.jra;
    endtask

    // Leaves the DUT in IDLE just after a falling edge.
    task automatic apply_reset;
        @(negedge CLK);
        nRST = 1'b0;
        drive('0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        stim_t st[$];
        obs_t  got, e;
        drive(S(0,0,1,0,0,0, '0, '0, '0));
        @(negedge CLK);
        sb.push_back(E(0,0,0,0,32'h40));
        got = {iREN, ivalid, halted, misalign, iaddr};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", got, e);
        end
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) st.push_back(S(0,0,1,0,0,0, '0, '0, '0));
        sb.push_back(E(0,0,0,0,32'h40));
        sb.push_back(E(1,1,0,0,32'h40));
        sb.push_back(E(1,1,0,0,32'h44));
        sb.push_back(E(1,1,0,0,32'h48));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            #1;
            got = {iREN, ivalid, halted, misalign, iaddr};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_seq step %0d: got %h expected %h", i, got, e);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_redirect;
        stim_t st[$];
        obs_t  got, e;
        apply_reset();
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,0,0,32'h40));
        st.push_back(S(0,0,1,0,0,1, '0, '0, 32'h100));          sb.push_back(E(1,1,0,0,32'h40));
        st.push_back(S(0,0,1,1,0,0, 16'hFFFE, '0, '0));         sb.push_back(E(1,1,0,0,32'h100));
        st.push_back(S(0,0,1,0,1,0, '0, 26'h10, '0));           sb.push_back(E(1,1,0,0,32'h0FC));
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(1,0,0,0,32'h040));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            #1;
            got = {iREN, ivalid, halted, misalign, iaddr};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL redirect step %0d: got %h expected %h", i, got, e);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_pending;
        stim_t st[$];
        obs_t  got, e;
        apply_reset();
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,0,0,32'h40));
        st.push_back(S(0,0,1,0,0,1, '0, '0, 32'h200));          sb.push_back(E(1,1,0,0,32'h40));
        st.push_back(S(0,0,0,0,1,0, '0, 26'h80, '0));           sb.push_back(E(1,0,0,0,32'h200));
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(1,0,0,0,32'h200));
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(1,1,0,0,32'h200));
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(1,1,0,0,32'h200));
        // older pending branch (0x248) is overwritten by a stalled jr to 0x300
        st.push_back(S(0,0,0,1,0,0, 16'h0010, '0, '0));         sb.push_back(E(1,0,0,0,32'h204));
        st.push_back(S(0,1,1,0,0,1, '0, '0, 32'h300));          sb.push_back(E(1,0,0,0,32'h204));
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(1,1,0,0,32'h204));
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(1,1,0,0,32'h300));
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(1,0,0,0,32'h304));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            #1;
            got = {iREN, ivalid, halted, misalign, iaddr};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pending step %0d: got %h expected %h", i, got, e);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_priority_stall;
        stim_t st[$];
        obs_t  got, e;
        apply_reset();
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));                    sb.push_back(E(0,0,0,0,32'h40));
        st.push_back(S(0,0,1,1,1,1, 16'h0008, 26'h5, 32'h1000));     sb.push_back(E(1,1,0,0,32'h40));
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(0,1,1,0,0,0, '0, '0, '0));                sb.push_back(E(1,0,0,0,32'h1000));
        end
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));                    sb.push_back(E(1,1,0,0,32'h1000));
        st.push_back(S(0,0,1,1,1,0, 16'h0100, 26'h20, '0));          sb.push_back(E(1,1,0,0,32'h1004));
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));                    sb.push_back(E(1,0,0,0,32'h080));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            #1;
            got = {iREN, ivalid, halted, misalign, iaddr};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL priority_stall step %0d: got %h expected %h", i, got, e);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_halt;
        stim_t st[$];
        obs_t  got, e;
        apply_reset();
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,0,0,32'h40));
        st.push_back(S(0,0,1,0,0,1, '0, '0, 32'h600));          sb.push_back(E(1,1,0,0,32'h40));
        st.push_back(S(1,1,1,0,0,0, '0, '0, '0));               sb.push_back(E(1,0,0,0,32'h600));
        st.push_back(S(1,0,1,1,0,0, 16'h0010, '0, '0));         sb.push_back(E(1,1,0,0,32'h600));
        st.push_back(S(0,0,1,0,0,1, '0, '0, 32'h500));          sb.push_back(E(0,0,1,0,32'h600));
        st.push_back(S(0,0,1,0,1,0, '0, 26'h33, '0));           sb.push_back(E(0,0,1,0,32'h600));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            #1;
            got = {iREN, ivalid, halted, misalign, iaddr};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL halt step %0d: got %h expected %h", i, got, e);
            end
            @(negedge CLK);
        end
        nRST = 1'b0;
        sb.push_back(E(0,0,0,0,32'h40));
        #1;
        got = {iREN, ivalid, halted, misalign, iaddr};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL halt_reset: got %h expected %h", got, e);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_jr_misalign;
        stim_t st[$];
        obs_t  got, e;
        apply_reset();
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,0,0,32'h40));
        st.push_back(S(0,0,1,0,0,1, '0, '0, 32'h1000));         sb.push_back(E(1,1,0,0,32'h40));
        st.push_back(S(0,0,1,0,0,1, '0, '0, 32'h1002));         sb.push_back(E(1,1,0,0,32'h1000));
`ifdef PC_ALIGN_CHECK_EN
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,1,1,32'h1000));
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,1,1,32'h1000));
`else
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(1,1,0,0,32'h1002));
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(1,1,0,0,32'h1006));
`endif
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            #1;
            got = {iREN, ivalid, halted, misalign, iaddr};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL jr_align step %0d: got %h expected %h", i, got, e);
            end
            @(negedge CLK);
        end
        // misaligned jr captured while the fetch is outstanding
        st.delete();
        apply_reset();
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,0,0,32'h40));
        st.push_back(S(0,0,0,0,0,1, '0, '0, 32'h1003));         sb.push_back(E(1,0,0,0,32'h40));
`ifdef PC_ALIGN_CHECK_EN
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,1,1,32'h40));
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(0,0,1,1,32'h40));
`else
        st.push_back(S(0,0,1,0,0,0, '0, '0, '0));               sb.push_back(E(1,1,0,0,32'h40));
        st.push_back(S(0,0,0,0,0,0, '0, '0, '0));               sb.push_back(E(1,0,0,0,32'h1003));
`endif
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            #1;
            got = {iREN, ivalid, halted, misalign, iaddr};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL jr_align_pending step %0d: got %h expected %h", i, got, e);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_pending();
        test_priority_stall();
        test_halt();
        test_jr_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
